// File: rtl/bsg_fsb_arb_pkg.sv
// Shared types and helpers for the FSB node arbiter: slot state, counter width,
// and destination-id extraction from a packet.
package bsg_fsb_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bsg_fsb_slot_state_e;

  localparam int bsg_fsb_cnt_width_lp = 16;
  localparam int bsg_fsb_data_max_lp  = 1024;

  // Callers zero-extend packets to bsg_fsb_data_max_lp bits before calling.
  function automatic logic [15:0] bsg_fsb_id_f(
    input logic [bsg_fsb_data_max_lp-1:0] data,
    input int unsigned                    lsb,
    input int unsigned                    width
  );
    return 16'(data >> lsb) & ((16'd1 << width) - 16'd1);
  endfunction

endpackage

// File: rtl/bsg_fsb_rr_arb.sv
// Round-robin picker: first requester at or after the pointer wins; the pointer
// moves past the winner only when the grant is actually taken (yumi_i).
module bsg_fsb_rr_arb
  import bsg_fsb_arb_pkg::*;
#(
  parameter int clients_p = 4,
  parameter int ptr_w_p   = $clog2(clients_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [clients_p-1:0] reqs_i,
  input  logic                 yumi_i,
  output logic [clients_p-1:0] grant_oh_o,
  output logic [ptr_w_p-1:0]   grant_id_o,
  output logic                 v_o
);

  localparam int sw_lp = ptr_w_p + 1;
  localparam logic [sw_lp-1:0] clients_lp = sw_lp'(clients_p);

  logic [ptr_w_p-1:0] ptr_q, ptr_d;
  logic [sw_lp-1:0]   sum;
  logic [sw_lp-1:0]   nxt;
  logic [ptr_w_p-1:0] idx;

  always_comb begin
    v_o        = 1'b0;
    grant_id_o = '0;
    sum        = '0;
    idx        = '0;
    for (int i = 0; i < clients_p; i++) begin
      sum = {1'b0, ptr_q} + sw_lp'(i);
      if (sum >= clients_lp) sum = sum - clients_lp;
      idx = sum[ptr_w_p-1:0];
      if (!v_o && reqs_i[idx]) begin
        v_o        = 1'b1;
        grant_id_o = idx;
      end
    end
  end

  assign grant_oh_o = v_o ? (clients_p'(1) << grant_id_o) : '0;

  always_comb begin
    nxt = {1'b0, grant_id_o} + sw_lp'(1);
    if (nxt == clients_lp) nxt = '0;
    ptr_d = (yumi_i && v_o) ? nxt[ptr_w_p-1:0] : ptr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_fsb_node_arbiter.sv
// Shares one FSB node slot among clients_p clients: round-robin outbound slot and
// id-routed inbound slot. Define BSG_FSB_NODE_ARBITER_STATS_EN for grant counters.
module bsg_fsb_node_arbiter
  import bsg_fsb_arb_pkg::*;
#(
  parameter int ring_width_p = 80,
  parameter int clients_p    = 4,
  parameter int id_lsb_p     = 72,
  parameter int id_width_p   = $clog2(clients_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      en_i,
  input  logic [clients_p-1:0]                      cl_v_i,
  input  logic [clients_p*ring_width_p-1:0]         cl_data_i,
  output logic [clients_p-1:0]                      cl_yumi_o,
  output logic                                      fsb_v_o,
  output logic [ring_width_p-1:0]                   fsb_data_o,
  input  logic                                      fsb_ready_i,
  input  logic                                      fsb_v_i,
  input  logic [ring_width_p-1:0]                   fsb_data_i,
  output logic                                      fsb_yumi_o,
  output logic [clients_p-1:0]                      cl_v_o,
  output logic [ring_width_p-1:0]                   cl_data_o,
  input  logic [clients_p-1:0]                      cl_ready_i,
  output logic                                      bad_id_o,
  output logic [clients_p*bsg_fsb_cnt_width_lp-1:0] grant_cnt_o
);

  localparam int ptr_w_lp = $clog2(clients_p);
  localparam logic [15:0] clients_lp = 16'(clients_p);

  // ---------------- outbound ----------------
  bsg_fsb_slot_state_e     out_state_q;
  logic [ring_width_p-1:0] out_data_q;
  logic [ring_width_p-1:0] cl_data_arr [clients_p];
  logic [clients_p-1:0]    grant_oh;
  logic [ptr_w_lp-1:0]     grant_id;
  logic                    arb_v;
  logic                    can_load;
  logic                    grant;

  for (genvar gi = 0; gi < clients_p; gi++) begin : g_slice
    assign cl_data_arr[gi] = cl_data_i[gi*ring_width_p +: ring_width_p];
  end

  assign can_load = en_i & ((out_state_q == EMPTY) | fsb_ready_i);
  assign grant    = can_load & arb_v;

  bsg_fsb_rr_arb #(
    .clients_p(clients_p),
    .ptr_w_p  (ptr_w_lp)
  ) arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .reqs_i    (cl_v_i),
    .yumi_i    (grant),
    .grant_oh_o(grant_oh),
    .grant_id_o(grant_id),
    .v_o       (arb_v)
  );

  // Acks are combinational, so mask them while reset is held.
  assign cl_yumi_o  = grant_oh & {clients_p{grant & ~reset_i}};
  assign fsb_v_o    = (out_state_q == FULL);
  assign fsb_data_o = out_data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_state_q <= EMPTY;
      out_data_q  <= '0;
    end else if (grant) begin
      out_state_q <= FULL;
      out_data_q  <= cl_data_arr[grant_id];
    end else if (out_state_q == FULL && fsb_ready_i) begin
      out_state_q <= EMPTY;
    end
  end

  // ---------------- inbound ----------------
  bsg_fsb_slot_state_e     in_state_q;
  logic [ring_width_p-1:0] in_data_q;
  logic [id_width_p-1:0]   in_cur_q;
  logic                    bad_q;
  logic [15:0]             in_id;
  logic                    in_bad;
  logic                    drain;
  logic                    accept;

  assign in_id  = bsg_fsb_id_f({{(bsg_fsb_data_max_lp-ring_width_p){1'b0}}, fsb_data_i},
                               id_lsb_p, id_width_p);
  assign in_bad = (in_id >= clients_lp);
  assign drain  = (in_state_q == FULL) & cl_ready_i[in_cur_q];
  assign accept = fsb_v_i & en_i & ((in_state_q == EMPTY) | drain);

  assign fsb_yumi_o = accept & ~reset_i;
  assign cl_v_o     = (in_state_q == FULL) ? (clients_p'(1) << in_cur_q) : '0;
  assign cl_data_o  = in_data_q;
  assign bad_id_o   = bad_q;

  // A bad-id packet is swallowed without disturbing the held packet's drain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_state_q <= EMPTY;
      in_data_q  <= '0;
      in_cur_q   <= '0;
      bad_q      <= 1'b0;
    end else begin
      if (accept && in_bad) bad_q <= 1'b1;
      if (accept && !in_bad) begin
        in_state_q <= FULL;
        in_data_q  <= fsb_data_i;
        in_cur_q   <= in_id[id_width_p-1:0];
      end else if (drain) begin
        in_state_q <= EMPTY;
      end
    end
  end

  // ---------------- grant statistics ----------------
`ifdef BSG_FSB_NODE_ARBITER_STATS_EN
  for (genvar gi = 0; gi < clients_p; gi++) begin : g_cnt
    logic [bsg_fsb_cnt_width_lp-1:0] cnt_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                              cnt_q <= '0;
      else if (cl_yumi_o[gi] && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
    end
    assign grant_cnt_o[gi*bsg_fsb_cnt_width_lp +: bsg_fsb_cnt_width_lp] = cnt_q;
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_fsb_node_arbiter.sv
// Directed bench for bsg_fsb_node_arbiter: a 4-client instance for arbitration and
// routing, plus a 3-client instance for out-of-range inbound ids.
module tb_bsg_fsb_node_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 4-client instance
  logic         en, fsb_ready, fsb_v_in;
  logic [3:0]   cl_v, cl_ready, cl_yumi, cl_v_out;
  logic [319:0] cl_data;
  logic [79:0]  fsb_data_in, fsb_data_out, cl_data_out;
  logic         fsb_v_out, fsb_yumi, bad_id;
  logic [63:0]  grant_cnt;

  // 3-client instance
  logic         en3, fsb_ready3, fsb_v3;
  logic [2:0]   cl_v3, cl_ready3, cl_yumi3, cl_v_out3;
  logic [239:0] cl_data3;
  logic [79:0]  fsb_data3, fsb_data_out3, cl_data_out3;
  logic         fsb_v_out3, fsb_yumi3, bad_id3;
  logic [47:0]  grant_cnt3;

  bsg_fsb_node_arbiter #(.ring_width_p(80), .clients_p(4), .id_lsb_p(72)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en),
    .cl_v_i(cl_v), .cl_data_i(cl_data), .cl_yumi_o(cl_yumi),
    .fsb_v_o(fsb_v_out), .fsb_data_o(fsb_data_out), .fsb_ready_i(fsb_ready),
    .fsb_v_i(fsb_v_in), .fsb_data_i(fsb_data_in), .fsb_yumi_o(fsb_yumi),
    .cl_v_o(cl_v_out), .cl_data_o(cl_data_out), .cl_ready_i(cl_ready),
    .bad_id_o(bad_id), .grant_cnt_o(grant_cnt)
  );

  bsg_fsb_node_arbiter #(.ring_width_p(80), .clients_p(3), .id_lsb_p(72)) dut3 (
    .clk_i(clk), .reset_i(rst), .en_i(en3),
    .cl_v_i(cl_v3), .cl_data_i(cl_data3), .cl_yumi_o(cl_yumi3),
    .fsb_v_o(fsb_v_out3), .fsb_data_o(fsb_data_out3), .fsb_ready_i(fsb_ready3),
    .fsb_v_i(fsb_v3), .fsb_data_i(fsb_data3), .fsb_yumi_o(fsb_yumi3),
    .cl_v_o(cl_v_out3), .cl_data_o(cl_data_out3), .cl_ready_i(cl_ready3),
    .bad_id_o(bad_id3), .grant_cnt_o(grant_cnt3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] pkt(input int id, input logic [71:0] payload);
    return (80'(id) << 72) | 80'(payload);
  endfunction

  logic [79:0] p2, p0, p1;
  int          g, prev;

  initial begin
    rst = 1'b1; en = 1'b1; fsb_ready = 1'b0; fsb_v_in = 1'b1; fsb_data_in = '0;
    cl_v = 4'hF; cl_ready = 4'h0; cl_data = '0;
    for (int k = 0; k < 4; k++) cl_data[k*80 +: 80] = 80'h1000 + 80'(k);
    en3 = 1'b1; fsb_ready3 = 1'b0; fsb_v3 = 1'b0; fsb_data3 = '0;
    cl_v3 = '0; cl_ready3 = 3'b111; cl_data3 = '0;
    tick(); tick();

    // reset state, with requests present
    chk("rst_fsb_v", 128'(fsb_v_out), 128'(0));
    chk("rst_fsb_data", 128'(fsb_data_out), 128'(0));
    chk("rst_cl_v", 128'(cl_v_out), 128'(0));
    chk("rst_cl_data", 128'(cl_data_out), 128'(0));
    chk("rst_cl_yumi", 128'(cl_yumi), 128'(0));
    chk("rst_fsb_yumi", 128'(fsb_yumi), 128'(0));
    chk("rst_bad", 128'(bad_id), 128'(0));
    chk("rst_cnt", 128'(grant_cnt), 128'(0));

    cl_v = 4'h0; fsb_v_in = 1'b0;
    rst = 1'b0;

    // all four clients valid: grants 0,1,2,3,0,... back-to-back
    fsb_ready = 1'b1; cl_v = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_yumi_%0d", i), 128'(cl_yumi), 128'(4'b1 << (i % 4)));
      if (i > 0) begin
        chk($sformatf("rr_v_%0d", i), 128'(fsb_v_out), 128'(1));
        chk($sformatf("rr_data_%0d", i), 128'(fsb_data_out), 128'(80'h1000 + 80'((i - 1) % 4)));
      end
      tick();
    end
`ifdef BSG_FSB_NODE_ARBITER_STATS_EN
    chk("cnt_after_rr", 128'(grant_cnt), 128'(64'h0002_0002_0002_0002));
`else
    chk("cnt_tied", 128'(grant_cnt), 128'(0));
`endif

    // move pointer to 2 via a single grant to client 1
    cl_v = 4'b0010;
    #1;
    chk("ptr_set_yumi", 128'(cl_yumi), 128'(4'b0010));
    chk("ptr_set_data", 128'(fsb_data_out), 128'(80'h1003));
    tick();

    // only clients 1 and 3 valid, ptr=2: 3,1,3,1
    cl_v = 4'b1010; prev = 1;
    for (int j = 0; j < 4; j++) begin
      g = (j % 2 == 0) ? 3 : 1;
      #1;
      chk($sformatf("sparse_yumi_%0d", j), 128'(cl_yumi), 128'(4'b1 << g));
      chk($sformatf("sparse_data_%0d", j), 128'(fsb_data_out), 128'(80'h1000 + 80'(prev)));
      tick();
      prev = g;
    end

    // back-pressure: slot holds 0x1001, no grants for 5 cycles
    fsb_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("stall_yumi_%0d", s), 128'(cl_yumi), 128'(0));
      chk($sformatf("stall_v_%0d", s), 128'(fsb_v_out), 128'(1));
      chk($sformatf("stall_data_%0d", s), 128'(fsb_data_out), 128'(80'h1001));
      tick();
    end
    fsb_ready = 1'b1;
    #1;
    chk("release_yumi", 128'(cl_yumi), 128'(4'b1000));
    tick();
    chk("release_data", 128'(fsb_data_out), 128'(80'h1003));
    cl_v = 4'b0000;
    #1;
    chk("idle_yumi", 128'(cl_yumi), 128'(0));
    tick();
    chk("drained_v", 128'(fsb_v_out), 128'(0));

    // en=0: a full slot drains but nothing new loads
    cl_v = 4'b0001;
    #1;
    chk("en_pre_yumi", 128'(cl_yumi), 128'(4'b0001));
    tick();
    en = 1'b0;
    #1;
    chk("en_off_yumi", 128'(cl_yumi), 128'(0));
    chk("en_off_v", 128'(fsb_v_out), 128'(1));
    tick();
    chk("en_off_drained", 128'(fsb_v_out), 128'(0));
    en = 1'b1; cl_v = 4'b0000;

    // inbound: id=2 held while client 2 not ready, id=0 waits behind it
    p2 = pkt(2, 72'hAA); p0 = pkt(0, 72'hBB);
    cl_ready = 4'b1011; fsb_v_in = 1'b1; fsb_data_in = p2;
    #1;
    chk("in_acc_id2", 128'(fsb_yumi), 128'(1));
    tick();
    fsb_data_in = p0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("in_hold_v_%0d", s), 128'(cl_v_out), 128'(4'b0100));
      chk($sformatf("in_hold_data_%0d", s), 128'(cl_data_out), 128'(p2));
      chk($sformatf("in_hold_yumi_%0d", s), 128'(fsb_yumi), 128'(0));
      tick();
    end
    cl_ready = 4'b1111;
    #1;
    chk("in_swap_yumi", 128'(fsb_yumi), 128'(1));
    tick();
    fsb_v_in = 1'b0;
    #1;
    chk("in_id0_v", 128'(cl_v_out), 128'(4'b0001));
    chk("in_id0_data", 128'(cl_data_out), 128'(p0));
    chk("in_idle_yumi", 128'(fsb_yumi), 128'(0));
    tick();
    chk("in_empty", 128'(cl_v_out), 128'(0));

    en = 1'b0; fsb_v_in = 1'b1;
    #1;
    chk("in_en_off_yumi", 128'(fsb_yumi), 128'(0));
    tick();
    chk("in_en_off_v", 128'(cl_v_out), 128'(0));
    en = 1'b1; fsb_v_in = 1'b0;

    // 3 clients: id=3 is dropped and flagged, id=1 then delivers
    p1 = pkt(1, 72'hDD);
    fsb_v3 = 1'b1; fsb_data3 = pkt(3, 72'hCC);
    #1;
    chk("bad_yumi", 128'(fsb_yumi3), 128'(1));
    tick();
    fsb_data3 = p1;
    #1;
    chk("bad_no_v", 128'(cl_v_out3), 128'(0));
    chk("bad_flag", 128'(bad_id3), 128'(1));
    chk("bad_next_yumi", 128'(fsb_yumi3), 128'(1));
    tick();
    fsb_v3 = 1'b0;
    #1;
    chk("bad_next_v", 128'(cl_v_out3), 128'(3'b010));
    chk("bad_next_data", 128'(cl_data_out3), 128'(p1));
    chk("bad_sticky", 128'(bad_id3), 128'(1));
    tick();
    chk("bad_sticky2", 128'(bad_id3), 128'(1));
    chk("bad_drained", 128'(cl_v_out3), 128'(0));

    // fill both slots, then reset asynchronously
    cl_v = 4'b0001; fsb_ready = 1'b0; cl_ready = 4'b0000;
    fsb_v_in = 1'b1; fsb_data_in = pkt(1, 72'hEE);
    #1;
    chk("full_out_yumi", 128'(cl_yumi), 128'(4'b0001));
    chk("full_in_yumi", 128'(fsb_yumi), 128'(1));
    tick();
    chk("full_out_v", 128'(fsb_v_out), 128'(1));
    chk("full_in_v", 128'(cl_v_out), 128'(4'b0010));
    rst = 1'b1;
    #1;
    chk("arst_fsb_v", 128'(fsb_v_out), 128'(0));
    chk("arst_fsb_data", 128'(fsb_data_out), 128'(0));
    chk("arst_cl_v", 128'(cl_v_out), 128'(0));
    chk("arst_cl_data", 128'(cl_data_out), 128'(0));
    chk("arst_cl_yumi", 128'(cl_yumi), 128'(0));
    chk("arst_fsb_yumi", 128'(fsb_yumi), 128'(0));
    chk("arst_bad3", 128'(bad_id3), 128'(0));
    chk("arst_cnt", 128'(grant_cnt), 128'(0));
    tick();
    cl_v = 4'b0000; fsb_v_in = 1'b0;
    rst = 1'b0;

`ifdef BSG_FSB_NODE_ARBITER_STATS_EN
    // saturation: 70000 grants to client 0
    cl_v = 4'b0001; fsb_ready = 1'b1;
    repeat (70000) tick();
    cl_v = 4'b0000;
    tick();
    chk("cnt_sat0", 128'(grant_cnt[15:0]), 128'(16'hFFFF));
    chk("cnt_sat_others", 128'(grant_cnt[63:16]), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
